// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection (sequential, branch,
// jump, jump-register, interrupt, exception) and the IF/ID pipeline register.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] IRQ_ADDR = 32'h8000_0004,
    parameter logic [31:0] EXC_ADDR = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    input  logic        exc_req,
    input  logic        irq,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        if_id_irq
);

    logic [31:0] pc_q, pc_d;
    logic        irq_pending_q, irq_pending_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        if_id_irq_q, if_id_irq_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic        irq_seen;
    logic        irq_take;

    always_comb begin
        // Kernel bit is sticky across sequential fetch; only the low 31 bits wrap.
        pc_plus4    = {pc_q[31], pc_q[30:0] + 31'd4};
        jump_target = {if_id_pc_plus4_q[31:28], if_id_instr_q[25:0], 2'b00};
        case (redirect_sel)
            2'd1:    redirect_target = jump_target;
            2'd2:    redirect_target = jr_target;
            default: redirect_target = branch_target;
        endcase
        irq_seen = irq_pending_q | irq;
        irq_take = irq_seen & ~pc_q[31];

        pc_d             = pc_q;
        irq_pending_d    = irq_seen;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_irq_d      = if_id_irq_q;

        if (exc_req || redirect) begin
            pc_d             = exc_req ? EXC_ADDR : redirect_target;
            if_id_instr_d    = '0;
            if_id_pc_d       = '0;
            if_id_pc_plus4_d = '0;
            if_id_valid_d    = 1'b0;
            if_id_irq_d      = 1'b0;
        end else if (stall) begin
            // Hold everything; a new irq is still captured into irq_pending.
        end else if (irq_take) begin
            pc_d             = IRQ_ADDR;
            irq_pending_d    = 1'b0;
            if_id_instr_d    = '0;
            if_id_pc_d       = pc_q;
            if_id_pc_plus4_d = pc_plus4;
            if_id_valid_d    = 1'b0;
            if_id_irq_d      = 1'b1;
        end else begin
            pc_d             = pc_plus4;
            if_id_instr_d    = rom_data;
            if_id_pc_d       = pc_q;
            if_id_pc_plus4_d = pc_plus4;
            if_id_valid_d    = 1'b1;
            if_id_irq_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q             <= RESET_PC;
            irq_pending_q    <= 1'b0;
            if_id_instr_q    <= '0;
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= '0;
            if_id_valid_q    <= 1'b0;
            if_id_irq_q      <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            irq_pending_q    <= irq_pending_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_irq_q      <= if_id_irq_d;
        end
    end

    assign rom_addr       = pc_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_valid    = if_id_valid_q;
    assign if_id_irq      = if_id_irq_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IRQ_ADDR = 32'h8000_0004;
    localparam logic [31:0] EXC_ADDR = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [1:0]  redirect_sel = 2'd0;
    logic [31:0] branch_target = '0;
    logic [31:0] jr_target = '0;
    logic        exc_req = 1'b0;
    logic        irq = 1'b0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        if_id_irq;

    instr_fetch #(.RESET_PC(RESET_PC), .IRQ_ADDR(IRQ_ADDR), .EXC_ADDR(EXC_ADDR)) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .stall(stall), .redirect(redirect), .redirect_sel(redirect_sel),
        .branch_target(branch_target), .jr_target(jr_target),
        .exc_req(exc_req), .irq(irq),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .if_id_irq(if_id_irq)
    );

    always #5 clk = ~clk;

    // ROM contents: a fixed J instruction at 0x40, scrambled words elsewhere.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0800_0015;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign rom_data = rom_word(rom_addr);

    // Reference model state
    logic [31:0] m_pc, m_instr, m_ipc, m_ip4;
    logic        m_pend, m_valid, m_irq;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_pend = 1'b0;
        m_instr = '0; m_ipc = '0; m_ip4 = '0; m_valid = 1'b0; m_irq = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = '0; m_ipc = '0; m_ip4 = '0; m_valid = 1'b0; m_irq = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] p4, tgt;
        logic        pend;
        p4   = {m_pc[31], m_pc[30:0] + 31'd4};
        pend = m_pend | irq;
        case (redirect_sel)
            2'd1:    tgt = {m_ip4[31:28], m_instr[25:0], 2'b00};
            2'd2:    tgt = jr_target;
            default: tgt = branch_target;
        endcase
        if (exc_req) begin
            m_pc = EXC_ADDR; model_bubble(); m_pend = pend;
        end else if (redirect) begin
            m_pc = tgt; model_bubble(); m_pend = pend;
        end else if (stall) begin
            m_pend = pend;
        end else if (pend && !m_pc[31]) begin
            m_instr = '0; m_ipc = m_pc; m_ip4 = p4; m_valid = 1'b0; m_irq = 1'b1;
            m_pc = IRQ_ADDR; m_pend = 1'b0;
        end else begin
            m_instr = rom_word(m_pc); m_ipc = m_pc; m_ip4 = p4; m_valid = 1'b1; m_irq = 1'b0;
            m_pc = p4; m_pend = pend;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rom_addr"}, rom_addr, m_pc);
        chk({tag, ".instr"}, if_id_instr, m_instr);
        chk({tag, ".pc"}, if_id_pc, m_ipc);
        chk({tag, ".pc_plus4"}, if_id_pc_plus4, m_ip4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        chk({tag, ".irq"}, {31'd0, if_id_irq}, {31'd0, m_irq});
    endtask

    // One clock: model consumes the currently driven inputs, DUT samples at the
    // edge, outputs are compared 1 time unit later.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; redirect = 1'b0; redirect_sel = 2'd0;
        exc_req = 1'b0; irq = 1'b0;
    endtask

    task automatic go_to(input logic [31:0] target, input string tag);
        redirect = 1'b1; redirect_sel = 2'd0; branch_target = target;
        cycle(tag);
        redirect = 1'b0;
    endtask

    initial begin
        // Reset state
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Sequential fetch after reset
        cycle("seq0");
        chk("seq0.addr_const", rom_addr, 32'h8000_0004);
        chk("seq0.pc_const", if_id_pc, 32'h8000_0000);
        cycle("seq1");
        cycle("seq2");
        chk("seq2.addr_const", rom_addr, 32'h8000_000C);

        // Stall for 3 cycles at 0x10
        go_to(32'h0000_0010, "br10");
        cycle("pre_stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) cycle("stall");
        chk("stall.addr_const", rom_addr, 32'h0000_0014);
        stall = 1'b0;
        cycle("unstall");
        chk("unstall.pc_const", if_id_pc, 32'h0000_0014);

        // Jump from IF/ID
        go_to(32'h0000_0040, "br40");
        cycle("fetch40");
        chk("fetch40.instr_const", if_id_instr, 32'h0800_0015);
        redirect = 1'b1; redirect_sel = 2'd1;
        cycle("jump");
        chk("jump.addr_const", rom_addr, 32'h0000_0054);
        idle_inputs();
        cycle("after_jump");

        // Interrupt in user mode, then in kernel mode
        go_to(32'h0000_0020, "br20");
        irq = 1'b1;
        cycle("irq_user");
        chk("irq_user.addr_const", rom_addr, IRQ_ADDR);
        chk("irq_user.pc_const", if_id_pc, 32'h0000_0020);
        irq = 1'b0;
        go_to(32'h8000_0020, "br_k20");
        irq = 1'b1;
        cycle("irq_kernel");
        irq = 1'b0;
        cycle("kernel1");
        cycle("kernel2");
        go_to(32'h0000_0100, "ret_user");
        cycle("irq_late");
        chk("irq_late.flag_const", {31'd0, if_id_irq}, 32'd1);

        // Exception overrides redirect
        exc_req = 1'b1; redirect = 1'b1; redirect_sel = 2'd2; jr_target = 32'h0000_0100;
        cycle("exc");
        chk("exc.addr_const", rom_addr, EXC_ADDR);
        idle_inputs();

        // Low-31-bit wrap with kernel bit preserved
        go_to(32'h7FFF_FFFC, "br_wrap_u");
        cycle("wrap_u");
        chk("wrap_u.addr_const", rom_addr, 32'h0000_0000);
        go_to(32'hFFFF_FFFC, "br_wrap_k");
        cycle("wrap_k");
        chk("wrap_k.addr_const", rom_addr, 32'h8000_0000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(3) == 0);
            redirect      = ($urandom_range(7) == 0);
            redirect_sel  = 2'($urandom_range(3));
            branch_target = {1'($urandom_range(1)), 29'($urandom), 2'b00};
            jr_target     = {1'($urandom_range(1)), 29'($urandom), 2'b00};
            exc_req       = ($urandom_range(15) == 0);
            irq           = ($urandom_range(7) == 0);
            cycle("rand");
        end
        idle_inputs();

        // Mid-operation reset discards a pending interrupt
        go_to(32'h8000_0200, "br_k200");
        irq = 1'b1;
        cycle("pend_k");
        irq = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b1;
        cycle("post_reset");
        go_to(32'h0000_0200, "br_u200");
        cycle("no_stale_irq");
        chk("no_stale_irq.valid_const", {31'd0, if_id_valid}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
